// File: rtl/uart_xmtr.sv
// rtl/uart_xmtr.sv - buffered 8N1-style UART transmitter with valid/ready byte input
module uart_xmtr #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tx_enable,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_sout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_d;
  logic                 sout_d, busy_d, ready_d, frame_done_d;
  logic                 push, pop, can_start, wrap;
  logic [DATA_BITS-1:0] head;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  assign head = mem[rd_ptr_q[AW-1:0]];

  // Next-state logic: FIFO pointers, bit timing and serial framing
  always_comb begin
    push      = tx_valid & tx_ready;
    can_start = tx_enable && (fifo_count != '0);
    wrap      = (baud_q == BAUD_LAST);
    pop       = 1'b0;
    state_d   = state_q;
    baud_d    = wrap ? '0 : baud_q + BW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (can_start) begin
          pop     = 1'b1;
          state_d = S_START;
          bit_d   = '0;
          shift_d = head;
          par_d   = (^head) ^ (PARITY == 2);
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (wrap) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 3'd1;
          end else if (can_start) begin
            // Back-to-back: next start bit follows the stop bit with no idle gap
            pop     = 1'b1;
            state_d = S_START;
            bit_d   = '0;
            shift_d = head;
            par_d   = (^head) ^ (PARITY == 2);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + CW'(1) : rd_ptr_q;
    count_d  = wr_ptr_d - rd_ptr_d;

    case (state_d)
      S_START: sout_d = 1'b0;
      S_DATA:  sout_d = shift_d[0];
      S_PAR:   sout_d = par_d;
      default: sout_d = 1'b1;
    endcase

    frame_done_d = (state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST);
    busy_d       = (state_d != S_IDLE) || (count_d != '0);
    ready_d      = (count_d != FULL_CNT);
  end

  // State and registered outputs; reset abandons any partial frame at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      uart_sout  <= 1'b1;
      busy       <= 1'b0;
      tx_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_count <= count_d;
      uart_sout  <= sout_d;
      busy       <= busy_d;
      tx_ready   <= ready_d;
      frame_done <= frame_done_d;
    end
  end

  // Byte storage; contents need no reset since pointers gate every read
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= tx_data;
  end

endmodule
